// File: rtl/hub75_byte_if.sv
// Byte-stream-in / framebuffer-write-out bus for the HUB75 byte loader.
//
// Upstream side (driven by the byte source, a UART/SPI bridge):
//   i_byte_data   8-bit stream byte
//   i_byte_valid  byte valid
//   i_sof         start of frame, qualified by i_byte_valid, marks the first R byte
//   o_byte_ready  byte accepted when i_byte_valid && o_byte_ready
// Downstream side (goes straight to the framebuffer write port):
//   o_wr_addr     linear pixel address (row*hpixel + col)
//   o_wr_data     packed pixel {R,G,B}
//   o_wr_en       single-cycle write strobe
//   o_frame_done  pulses together with the write of the last pixel of a frame
//   o_sync_err    pulses when a new frame starts before the current one completed
//
// addr_width_p / data_width_p must match the loader's derived widths
// ($clog2(hpixel*vpixel) and 3*bpp).
interface hub75_byte_if #(
  parameter int addr_width_p = 12,
  parameter int data_width_p = 24
);
  logic [7:0]              i_byte_data;
  logic                    i_byte_valid;
  logic                    i_sof;
  logic                    o_byte_ready;
  logic [addr_width_p-1:0] o_wr_addr;
  logic [data_width_p-1:0] o_wr_data;
  logic                    o_wr_en;
  logic                    o_frame_done;
  logic                    o_sync_err;

  // Byte source / test driver view.
  modport master (
    output i_byte_data, i_byte_valid, i_sof,
    input  o_byte_ready, o_wr_addr, o_wr_data, o_wr_en, o_frame_done, o_sync_err
  );

  // Loader view.
  modport slave (
    input  i_byte_data, i_byte_valid, i_sof,
    output o_byte_ready, o_wr_addr, o_wr_data, o_wr_en, o_frame_done, o_sync_err
  );
endinterface

// File: rtl/hub75_byte_loader.sv
// hub75_byte_loader
//
// Packs an R,G,B byte stream (row-major frames) into {R,G,B} pixel words and
// issues single-cycle framebuffer writes at linear addresses 0..hpixel*vpixel-1.
// Each colour channel keeps the bpp_p most significant bits of its byte.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   i_enable  loader enable; low forces the loader idle and drops any partial pixel
//   bus       hub75_byte_if slave modport (byte stream in, framebuffer write out)
//
// Timing: the pixel write appears on the cycle after its B byte is accepted.
// The loader never back-pressures: o_byte_ready = i_enable && !rst.
module hub75_byte_loader #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_enable,
  hub75_byte_if.slave  bus
);

  localparam int frame_size_p = hpixel_p * vpixel_p;
  localparam int addr_width_p = (frame_size_p > 1) ? $clog2(frame_size_p) : 1;
  localparam logic [addr_width_p-1:0] last_addr_p = addr_width_p'(frame_size_p - 1);

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_get_g = 2'd1;
  localparam logic [1:0] st_get_b = 2'd2;
  localparam logic [1:0] st_get_r = 2'd3;

  // Channel reduction: keep the MSBs of the byte.
  function automatic logic [bpp_p-1:0] chan_trunc(input logic [7:0] b);
    return b[7 -: bpp_p];
  endfunction

  logic [1:0]              state_q;
  logic [addr_width_p-1:0] pix_cnt_q;
  logic                    accept;
  logic                    mid_frame;
  logic [bpp_p-1:0]        byte_chan;

  logic [bpp_p-1:0]        r_p0;
  logic [bpp_p-1:0]        g_p0;

  logic [addr_width_p-1:0] wr_addr_p1;
  logic [3*bpp_p-1:0]      wr_data_p1;
  logic                    vld_p1;
  logic                    done_p1;
  logic                    err_p1;

  assign bus.o_byte_ready = i_enable && !rst;
  assign accept           = bus.i_byte_valid && bus.o_byte_ready;
  assign byte_chan        = chan_trunc(bus.i_byte_data);

  // A frame counts as "in progress" once any byte after SOF was taken, except
  // in the R-wait state when no pixel has been written yet.
  assign mid_frame = (state_q != st_idle) &&
                     !((state_q == st_get_r) && (pix_cnt_q == '0));

  // Stage p0: channel capture. R is taken on SOF or in the R-wait state, G in
  // the G-wait state; B is never stored, it goes straight into the write word.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (bus.i_sof || (state_q == st_get_r)) begin
        r_p0 <= byte_chan;
      end
      if (!bus.i_sof && (state_q == st_get_g)) begin
        g_p0 <= byte_chan;
      end
    end
  end

  // Stage p1: FSM, pixel counter and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= st_idle;
      pix_cnt_q  <= '0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      vld_p1     <= 1'b0;
      done_p1    <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;

      if (!i_enable) begin
        // Disabled: abandon any partial pixel silently. A write registered on
        // the previous cycle has already been presented on the outputs.
        state_q   <= st_idle;
        pix_cnt_q <= '0;
      end else if (accept) begin
        if (bus.i_sof) begin
          // SOF always restarts the frame; the byte is the new frame's R.
          err_p1    <= mid_frame;
          pix_cnt_q <= '0;
          state_q   <= st_get_g;
        end else begin
          case (state_q)
            st_get_g: state_q <= st_get_b;
            st_get_r: state_q <= st_get_g;
            st_get_b: begin
              vld_p1     <= 1'b1;
              wr_addr_p1 <= pix_cnt_q;
              wr_data_p1 <= {r_p0, g_p0, byte_chan};
              if (pix_cnt_q == last_addr_p) begin
                done_p1   <= 1'b1;
                pix_cnt_q <= '0;
                state_q   <= st_idle;
              end else begin
                pix_cnt_q <= pix_cnt_q + addr_width_p'(1);
                state_q   <= st_get_r;
              end
            end
            default: state_q <= st_idle;  // idle: non-SOF bytes are dropped
          endcase
        end
      end
    end
  end

  assign bus.o_wr_addr    = wr_addr_p1;
  assign bus.o_wr_data    = wr_data_p1;
  assign bus.o_wr_en      = vld_p1;
  assign bus.o_frame_done = done_p1;
  assign bus.o_sync_err   = err_p1;

endmodule

// File: tb/tb_hub75_byte_loader.sv
// Directed testbench for hub75_byte_loader: a 64x64 8-bpp instance and a
// 2x1 4-bpp instance share clock, reset, enable and the byte stream.
module tb_hub75_byte_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       sof;

  int errors = 0;
  int checks = 0;

  logic [7:0] r, g, b;

  always #5 clk = ~clk;

  hub75_byte_if #(.addr_width_p(12), .data_width_p(24)) bus8 ();
  hub75_byte_if #(.addr_width_p(1),  .data_width_p(12)) bus4 ();

  assign bus8.i_byte_data  = byte_data;
  assign bus8.i_byte_valid = byte_valid;
  assign bus8.i_sof        = sof;
  assign bus4.i_byte_data  = byte_data;
  assign bus4.i_byte_valid = byte_valid;
  assign bus4.i_sof        = sof;

  hub75_byte_loader #(.hpixel_p(64), .vpixel_p(64), .bpp_p(8)) u8 (
    .clk      (clk),
    .rst      (rst),
    .i_enable (enable),
    .bus      (bus8)
  );

  hub75_byte_loader #(.hpixel_p(2), .vpixel_p(1), .bpp_p(4)) u4 (
    .clk      (clk),
    .rst      (rst),
    .i_enable (enable),
    .bus      (bus4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock edge; outputs are sampled 1 time unit later.
  task automatic send(input logic [7:0] d, input logic s);
    byte_data  = d;
    sof        = s;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    sof        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                     input logic s);
    send(pr, s);
    send(pg, 1'b0);
    send(pb, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    sof        = 1'b0;
    idle(2);

    // Reset state
    chk("rst_ready", 32'(bus8.o_byte_ready), 32'd0);
    enable = 1'b1;
    #1;
    chk("rst_ready_en", 32'(bus8.o_byte_ready), 32'd0);
    chk("rst_wren", 32'(bus8.o_wr_en), 32'd0);
    chk("rst_addr", 32'(bus8.o_wr_addr), 32'd0);
    chk("rst_data", 32'(bus8.o_wr_data), 32'd0);
    chk("rst_done", 32'(bus8.o_frame_done), 32'd0);
    chk("rst_err", 32'(bus8.o_sync_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_on", 32'(bus8.o_byte_ready), 32'd1);

    // Test 1: single pixel
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    chk("t1_no_early_wr", 32'(bus8.o_wr_en), 32'd0);
    send(8'h33, 1'b0);
    chk("t1_wren", 32'(bus8.o_wr_en), 32'd1);
    chk("t1_addr", 32'(bus8.o_wr_addr), 32'd0);
    chk("t1_data", 32'(bus8.o_wr_data), 32'h112233);
    chk("t1_done", 32'(bus8.o_frame_done), 32'd0);
    idle(1);
    chk("t1_wren_pulse", 32'(bus8.o_wr_en), 32'd0);
    chk("t1_data_hold", 32'(bus8.o_wr_data), 32'h112233);

    // Drop enable for a cycle so the full frame below starts from idle.
    enable = 1'b0;
    idle(1);
    enable = 1'b1;

    // Test 2: full 64x64 frame with random valid gaps
    for (int p = 0; p < 4096; p++) begin
      r = p[7:0];
      g = {p[11:8], 4'h9};
      b = 8'(p * 7);
      if ($urandom_range(0, 3) == 0) idle(1);
      send(r, p == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      send(g, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
      send(b, 1'b0);
      chk("t2_wren", 32'(bus8.o_wr_en), 32'd1);
      chk("t2_addr", 32'(bus8.o_wr_addr), 32'(p));
      chk("t2_data", 32'(bus8.o_wr_data), {8'h00, r, g, b});
      chk("t2_done", 32'(bus8.o_frame_done), (p == 4095) ? 32'd1 : 32'd0);
      chk("t2_err", 32'(bus8.o_sync_err), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      send(8'(8'hE0 + i), 1'b0);
      chk("t2_drop_wren", 32'(bus8.o_wr_en), 32'd0);
      chk("t2_drop_err", 32'(bus8.o_sync_err), 32'd0);
    end

    // Test 3: SOF after 5 pixels + R byte, then SOF mid-pixel
    for (int p = 0; p < 5; p++) begin
      pix(8'(p), 8'h10, 8'h20, p == 0);
      chk("t3_addr", 32'(bus8.o_wr_addr), 32'(p));
    end
    send(8'hAA, 1'b0);
    chk("t3_r_no_wr", 32'(bus8.o_wr_en), 32'd0);
    send(8'h44, 1'b1);
    chk("t3_err", 32'(bus8.o_sync_err), 32'd1);
    chk("t3_err_no_wr", 32'(bus8.o_wr_en), 32'd0);
    idle(1);
    chk("t3_err_pulse", 32'(bus8.o_sync_err), 32'd0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    chk("t3_wren", 32'(bus8.o_wr_en), 32'd1);
    chk("t3_addr0", 32'(bus8.o_wr_addr), 32'd0);
    chk("t3_data", 32'(bus8.o_wr_data), 32'h445566);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h07, 1'b1);
    chk("t3_midpix_err", 32'(bus8.o_sync_err), 32'd1);
    chk("t3_midpix_no_wr", 32'(bus8.o_wr_en), 32'd0);
    send(8'h08, 1'b0);
    send(8'h09, 1'b0);
    chk("t3_midpix_addr", 32'(bus8.o_wr_addr), 32'd0);
    chk("t3_midpix_data", 32'(bus8.o_wr_data), 32'h070809);

    // Test 4: bytes without SOF after reset are dropped
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(8'(8'hA0 + i), 1'b0);
      chk("t4_drop_wren", 32'(bus8.o_wr_en), 32'd0);
      chk("t4_drop_err", 32'(bus8.o_sync_err), 32'd0);
    end
    pix(8'h10, 8'h20, 8'h30, 1'b1);
    chk("t4_wren", 32'(bus8.o_wr_en), 32'd1);
    chk("t4_addr", 32'(bus8.o_wr_addr), 32'd0);
    chk("t4_data", 32'(bus8.o_wr_data), 32'h102030);
    chk("t4_err", 32'(bus8.o_sync_err), 32'd0);
    pix(8'h40, 8'h50, 8'h60, 1'b0);
    chk("t4_addr1", 32'(bus8.o_wr_addr), 32'd1);

    // Test 5: enable dropped after G of pixel 10
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int p = 0; p < 10; p++) begin
      pix(8'h01, 8'h02, 8'(p), p == 0);
      chk("t5_addr", 32'(bus8.o_wr_addr), 32'(p));
    end
    send(8'h5A, 1'b0);
    send(8'h5B, 1'b0);
    enable = 1'b0;
    #1;
    chk("t5_ready_off", 32'(bus8.o_byte_ready), 32'd0);
    send(8'h5C, 1'b0);
    chk("t5_no_wr", 32'(bus8.o_wr_en), 32'd0);
    chk("t5_no_err", 32'(bus8.o_sync_err), 32'd0);
    idle(1);
    enable = 1'b1;
    #1;
    chk("t5_ready_on", 32'(bus8.o_byte_ready), 32'd1);
    send(8'hC1, 1'b1);
    chk("t5_sof_no_err", 32'(bus8.o_sync_err), 32'd0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    chk("t5_wren", 32'(bus8.o_wr_en), 32'd1);
    chk("t5_addr", 32'(bus8.o_wr_addr), 32'd0);
    chk("t5_data", 32'(bus8.o_wr_data), 32'hC1C2C3);

    // Test 6: 4-bpp instance, reset mid-frame, 2-pixel frame end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    pix(8'hAB, 8'hCD, 8'hEF, 1'b1);
    chk("t6_wren", 32'(bus4.o_wr_en), 32'd1);
    chk("t6_addr", 32'(bus4.o_wr_addr), 32'd0);
    chk("t6_data", 32'(bus4.o_wr_data), 32'hACE);
    chk("t6_done0", 32'(bus4.o_frame_done), 32'd0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    rst        = 1'b1;
    byte_data  = 8'h33;
    byte_valid = 1'b1;
    #1;
    chk("t6_ready_rst", 32'(bus4.o_byte_ready), 32'd0);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("t6_rst_wren", 32'(bus4.o_wr_en), 32'd0);
    chk("t6_rst_addr", 32'(bus4.o_wr_addr), 32'd0);
    chk("t6_rst_data", 32'(bus4.o_wr_data), 32'd0);
    chk("t6_rst_done", 32'(bus4.o_frame_done), 32'd0);
    chk("t6_rst_err", 32'(bus4.o_sync_err), 32'd0);
    chk("t6_rst_data8", 32'(bus8.o_wr_data), 32'd0);
    rst = 1'b0;
    pix(8'hAB, 8'hCD, 8'hEF, 1'b1);
    chk("t6_re_addr", 32'(bus4.o_wr_addr), 32'd0);
    chk("t6_re_data", 32'(bus4.o_wr_data), 32'hACE);
    pix(8'h12, 8'h34, 8'h56, 1'b0);
    chk("t6_last_wren", 32'(bus4.o_wr_en), 32'd1);
    chk("t6_last_addr", 32'(bus4.o_wr_addr), 32'd1);
    chk("t6_last_data", 32'(bus4.o_wr_data), 32'h135);
    chk("t6_last_done", 32'(bus4.o_frame_done), 32'd1);
    idle(1);
    chk("t6_done_pulse", 32'(bus4.o_frame_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
